// File: rtl/mem_io_pkg.sv
// Shared constants and helpers for the MIPS150 memory map / IO controller.
package mem_io_pkg;

  // Region decode on addr[31:28], expressed as (mask, value) pairs.
  // A region hits when (addr[31:28] & MASK) == VAL.
  localparam logic [3:0] REGION_DMEM_MASK = 4'b1001;
  localparam logic [3:0] REGION_DMEM_VAL  = 4'b0001;
  localparam logic [3:0] REGION_IMEM_MASK = 4'b1010;
  localparam logic [3:0] REGION_IMEM_VAL  = 4'b0010;
  localparam logic [3:0] REGION_IO_MASK   = 4'b1111;
  localparam logic [3:0] REGION_IO_VAL    = 4'b1000;

  // IO register offsets (addr[7:0]).
  localparam logic [7:0] IO_TX_STAT = 8'h00;
  localparam logic [7:0] IO_RX_STAT = 8'h04;
  localparam logic [7:0] IO_RX_DATA = 8'h08;
  localparam logic [7:0] IO_TX_DATA = 8'h0C;
  localparam logic [7:0] IO_CYC     = 8'h10;
  localparam logic [7:0] IO_INSTR   = 8'h14;
  localparam logic [7:0] IO_CNT_CLR = 8'h18;

  typedef enum logic [2:0] {
    IO_SEL_NONE,
    IO_SEL_TX_STAT,
    IO_SEL_RX_STAT,
    IO_SEL_RX_DATA,
    IO_SEL_TX_DATA,
    IO_SEL_CYC,
    IO_SEL_INSTR,
    IO_SEL_CNT_CLR
  } io_sel_e;

  function automatic logic region_hit(input logic [3:0] region,
                                      input logic [3:0] mask,
                                      input logic [3:0] val);
    return (region & mask) == val;
  endfunction

  function automatic io_sel_e io_sel_decode(input logic [7:0] offset);
    case (offset)
      IO_TX_STAT: return IO_SEL_TX_STAT;
      IO_RX_STAT: return IO_SEL_RX_STAT;
      IO_RX_DATA: return IO_SEL_RX_DATA;
      IO_TX_DATA: return IO_SEL_TX_DATA;
      IO_CYC:     return IO_SEL_CYC;
      IO_INSTR:   return IO_SEL_INSTR;
      IO_CNT_CLR: return IO_SEL_CNT_CLR;
      default:    return IO_SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead head data.
// Push while full and pop while empty are silently ignored, so callers
// may drive push/pop without pre-qualifying them.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (AW + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory-map decode and memory-mapped IO for the 3-stage MIPS150 core.
// Sits beside the X stage: decode outputs and IO read data are combinational
// from the X-stage address; the core registers io_rdata into M.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  store_mask,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        instr_valid,
  output logic [3:0]  store_mask_dmem,
  output logic [3:0]  store_mask_imem,
  output logic        load_dmem_or_io,
  output logic [31:0] io_rdata,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  logic [3:0]       region;
  logic             is_dmem;
  logic             is_imem;
  logic             is_io;
  logic             io_wr;
  logic             io_rd;
  io_sel_e          io_sel;

  logic             rx_push;
  logic             rx_pop;
  logic             rx_full;
  logic             rx_empty;
  logic [7:0]       rx_head;

  logic             tx_full;
  logic [7:0]       tx_byte;
  logic             tx_wr;

  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             cnt_clr;

  // Only the region nibble and the low offset byte participate in decode,
  // and the TX register keeps just the low byte of the store data.
  logic unused_bits;
  assign unused_bits = ^{addr[27:8], store_data[31:8]};

  assign region  = addr[31:28];
  assign is_dmem = region_hit(region, REGION_DMEM_MASK, REGION_DMEM_VAL);
  assign is_imem = region_hit(region, REGION_IMEM_MASK, REGION_IMEM_VAL);
  assign is_io   = region_hit(region, REGION_IO_MASK, REGION_IO_VAL);
  assign io_sel  = io_sel_decode(addr[7:0]);

  assign io_wr   = is_io && (store_mask != 4'b0000);
  assign io_rd   = is_io && mem_read;

  // Region decode into write enables and the load-source select.
  always_comb begin
    store_mask_dmem = is_dmem ? store_mask : 4'b0000;
    store_mask_imem = is_imem ? store_mask : 4'b0000;
    load_dmem_or_io = is_io;
  end

  // RX path: accept whenever there is room; a load of the RX data register
  // pops at the edge while the pre-pop head is returned this cycle.
  assign uart_rx_ready = !rx_full;
  assign rx_push       = uart_rx_valid && uart_rx_ready;
  assign rx_pop        = io_rd && (io_sel == IO_SEL_RX_DATA);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (uart_rx_data),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .head_data (rx_head)
  );

  assign tx_wr   = io_wr && (io_sel == IO_SEL_TX_DATA);
  assign cnt_clr = io_wr && (io_sel == IO_SEL_CNT_CLR);

  // TX holding register: a write is only taken while empty, so a write that
  // coincides with the draining handshake is dropped and the byte stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_full <= 1'b0;
      tx_byte <= 8'h00;
    end else if (tx_full) begin
      if (uart_tx_ready) tx_full <= 1'b0;
    end else if (tx_wr) begin
      tx_full <= 1'b1;
      tx_byte <= store_data[7:0];
    end
  end

  assign uart_tx_valid = tx_full;
  assign uart_tx_data  = tx_byte;

  // Free-running cycle counter and retired-instruction counter; clear wins.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (instr_valid) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  // IO read mux; write-only and unmapped offsets read as zero.
  always_comb begin
    io_rdata = 32'h0000_0000;
    case (io_sel)
      IO_SEL_TX_STAT: io_rdata = {31'b0, !tx_full};
      IO_SEL_RX_STAT: io_rdata = {31'b0, !rx_empty};
      IO_SEL_RX_DATA: io_rdata = rx_empty ? 32'h0000_0000 : {24'b0, rx_head};
      IO_SEL_CYC:     io_rdata = 32'(cyc_cnt);
      IO_SEL_INSTR:   io_rdata = 32'(instr_cnt);
      default:        io_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: decode vector table, RX scoreboard,
// TX / counter / reset sequences, and a narrow-counter instance for wrap.
module tb_mem_io_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [3:0]  store_mask;
  logic [31:0] store_data;
  logic        mem_read;
  logic        instr_valid;
  logic [3:0]  store_mask_dmem;
  logic [3:0]  store_mask_imem;
  logic        load_dmem_or_io;
  logic [31:0] io_rdata;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  logic [3:0]  unused4_dmem;
  logic [3:0]  unused4_imem;
  logic        unused4_lio;
  logic [31:0] io_rdata4;
  logic        unused4_rx_ready;
  logic [7:0]  unused4_tx_data;
  logic        unused4_tx_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  logic [31:0] sb_q[$];
  logic [7:0]  rx_exp[$];

  typedef struct {
    logic [31:0] a;
    logic [3:0]  m;
    logic        rd;
    logic [3:0]  exp_dmem;
    logic [3:0]  exp_imem;
    logic        exp_io;
  } dec_vec_t;

  dec_vec_t dv [10];

  mem_io_ctrl #(.RX_DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .store_mask(store_mask),
    .store_data(store_data), .mem_read(mem_read), .instr_valid(instr_valid),
    .store_mask_dmem(store_mask_dmem), .store_mask_imem(store_mask_imem),
    .load_dmem_or_io(load_dmem_or_io), .io_rdata(io_rdata),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
  );

  // 4-bit counter instance parked on the cycle-count register to observe wrap.
  mem_io_ctrl #(.RX_DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .addr(32'h8000_0010), .store_mask(4'b0000),
    .store_data(32'h0), .mem_read(1'b0), .instr_valid(1'b0),
    .store_mask_dmem(unused4_dmem), .store_mask_imem(unused4_imem),
    .load_dmem_or_io(unused4_lio), .io_rdata(io_rdata4),
    .uart_rx_data(8'h00), .uart_rx_valid(1'b0),
    .uart_rx_ready(unused4_rx_ready), .uart_tx_data(unused4_tx_data),
    .uart_tx_valid(unused4_tx_valid), .uart_tx_ready(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edges = rst ? 0 : edges + 1;
    #1;
  endtask

  task automatic idle();
    addr          = 32'h0;
    store_mask    = 4'b0000;
    store_data    = 32'h0;
    mem_read      = 1'b0;
    instr_valid   = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
  endtask

  // Combinational IO read through the scoreboard; no clock edge.
  task automatic io_rd(input logic [7:0] off, input string name, input logic [31:0] exp);
    addr       = {24'h800000, off};
    store_mask = 4'b0000;
    mem_read   = 1'b1;
    sb_q.push_back(exp);
    #1;
    check(name, io_rdata, sb_q.pop_front());
  endtask

  task automatic io_wr(input logic [7:0] off, input logic [31:0] d);
    addr       = {24'h800000, off};
    store_mask = 4'b1111;
    store_data = d;
    mem_read   = 1'b0;
    tick();
    idle();
  endtask

  // One RX cycle: optional byte offer and optional load of RX data.
  task automatic rx_step(input logic push_en, input logic [7:0] b, input logic pop_en);
    logic can_push;
    can_push      = rx_exp.size() < 8;
    uart_rx_valid = push_en;
    uart_rx_data  = b;
    #1;
    check("rx_ready", {31'b0, uart_rx_ready}, {31'b0, can_push});
    if (pop_en) begin
      io_rd(8'h08, "rx_data", (rx_exp.size() > 0) ? {24'b0, rx_exp[0]} : 32'h0);
      if (rx_exp.size() > 0) rx_exp.delete(0);
    end
    if (push_en && can_push) rx_exp.push_back(b);
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] iv_pat;
    dv[0] = '{32'h1000_0004, 4'b1111, 1'b0, 4'b1111, 4'b0000, 1'b0};
    dv[1] = '{32'h3000_0000, 4'b1100, 1'b0, 4'b1100, 4'b1100, 1'b0};
    dv[2] = '{32'h8000_0008, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1};
    dv[3] = '{32'h2000_0010, 4'b0011, 1'b0, 4'b0000, 4'b0011, 1'b0};
    dv[4] = '{32'h5000_0000, 4'b1010, 1'b0, 4'b1010, 4'b0000, 1'b0};
    dv[5] = '{32'h7000_0000, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b0};
    dv[6] = '{32'h4000_0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0};
    dv[7] = '{32'h9000_0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0};
    dv[8] = '{32'hF000_0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
    dv[9] = '{32'h8000_0040, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1};

    rst = 1'b1;
    uart_tx_ready = 1'b0;
    idle();
    tick();
    addr = 32'h1000_0000;
    store_mask = 4'b1111;
    #1;
    check("dec_in_reset", {28'b0, store_mask_dmem}, 32'hF);
    idle();
    tick();
    check("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
    rst = 1'b0;
    io_rd(8'h10, "rst_cyc", 32'd0);
    io_rd(8'h14, "rst_instr", 32'd0);
    idle();

    // Counters: 10 edges, instr_valid on 6 of them.
    iv_pat = 10'b1011011010;
    for (int i = 0; i < 10; i++) begin
      instr_valid = iv_pat[i];
      tick();
    end
    instr_valid = 1'b0;
    io_rd(8'h10, "cyc_10", 32'd10);
    io_rd(8'h14, "instr_6", 32'd6);
    instr_valid = 1'b1;
    io_wr(8'h18, 32'h1);
    io_rd(8'h10, "cyc_clr", 32'd0);
    io_rd(8'h14, "instr_clr", 32'd0);
    idle();
    tick();
    io_rd(8'h10, "cyc_after_clr", 32'd1);
    io_rd(8'h14, "instr_after_clr", 32'd0);
    idle();

    // Region decode table.
    for (int i = 0; i < 10; i++) begin
      addr       = dv[i].a;
      store_mask = dv[i].m;
      mem_read   = dv[i].rd;
      #1;
      check($sformatf("dec%0d_dmem", i), {28'b0, store_mask_dmem}, {28'b0, dv[i].exp_dmem});
      check($sformatf("dec%0d_imem", i), {28'b0, store_mask_imem}, {28'b0, dv[i].exp_imem});
      check($sformatf("dec%0d_io", i), {31'b0, load_dmem_or_io}, {31'b0, dv[i].exp_io});
      tick();
      idle();
    end
    io_rd(8'h00, "tx_stat_after_dec", 32'h1);
    idle();

    // RX: two bytes in, two out in order, then empty.
    rx_step(1'b1, 8'h41, 1'b0);
    rx_step(1'b1, 8'h42, 1'b0);
    io_rd(8'h04, "rx_stat_2", 32'h1);
    idle();
    rx_step(1'b0, 8'h00, 1'b1);
    rx_step(1'b0, 8'h00, 1'b1);
    io_rd(8'h04, "rx_stat_0", 32'h0);
    idle();
    rx_step(1'b0, 8'h00, 1'b1);

    // RX: fill to full (pointers wrap), overflow offer, pop at full.
    for (int i = 0; i < 8; i++) rx_step(1'b1, 8'hA0 + 8'(i), 1'b0);
    check("rx_full_ready", {31'b0, uart_rx_ready}, 32'h0);
    rx_step(1'b1, 8'hEE, 1'b0);
    rx_step(1'b1, 8'hEF, 1'b1);
    check("rx_ready_after_pop", {31'b0, uart_rx_ready}, 32'h1);
    for (int i = 0; i < 7; i++) rx_step(1'b0, 8'h00, 1'b1);
    io_rd(8'h04, "rx_stat_drained", 32'h0);
    idle();

    // RX: push and pop in the same cycle keeps order.
    rx_step(1'b1, 8'h11, 1'b0);
    rx_step(1'b1, 8'h22, 1'b1);
    rx_step(1'b0, 8'h00, 1'b1);
    io_rd(8'h04, "rx_stat_pp", 32'h0);
    idle();

    // TX holding register.
    uart_tx_ready = 1'b0;
    io_wr(8'h0C, 32'h0000_0055);
    check("tx_valid_55", {31'b0, uart_tx_valid}, 32'h1);
    check("tx_data_55", {24'b0, uart_tx_data}, 32'h55);
    io_rd(8'h00, "tx_stat_full", 32'h0);
    idle();
    io_wr(8'h0C, 32'h0000_0066);
    check("tx_drop_data", {24'b0, uart_tx_data}, 32'h55);
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    check("tx_valid_sent", {31'b0, uart_tx_valid}, 32'h0);
    io_rd(8'h00, "tx_stat_empty", 32'h1);
    idle();
    io_wr(8'h0C, 32'h0000_0066);
    check("tx_valid_66", {31'b0, uart_tx_valid}, 32'h1);
    check("tx_data_66", {24'b0, uart_tx_data}, 32'h66);
    uart_tx_ready = 1'b1;
    io_wr(8'h0C, 32'h0000_0077);
    uart_tx_ready = 1'b0;
    check("tx_hs_drop_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("tx_hs_drop_data", {24'b0, uart_tx_data}, 32'h66);
    io_wr(8'h0C, 32'h0000_0088);
    check("tx_data_88", {24'b0, uart_tx_data}, 32'h88);

    // Reset with TX pending and three RX bytes queued.
    rx_step(1'b1, 8'h31, 1'b0);
    rx_step(1'b1, 8'h32, 1'b0);
    rx_step(1'b1, 8'h33, 1'b0);
    rst = 1'b1;
    addr = 32'h3000_0000;
    store_mask = 4'b0011;
    #1;
    check("rst_dec_imem", {28'b0, store_mask_imem}, 32'h3);
    tick();
    rst = 1'b0;
    idle();
    rx_exp.delete();
    check("rst2_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("rst2_tx_data", {24'b0, uart_tx_data}, 32'h0);
    check("rst2_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    io_rd(8'h04, "rst2_rx_stat", 32'h0);
    io_rd(8'h08, "rst2_rx_data", 32'h0);
    io_rd(8'h10, "rst2_cyc", 32'h0);
    io_rd(8'h14, "rst2_instr", 32'h0);
    idle();

    // Narrow counter wraps at 2^CNT_W.
    for (int i = 0; i < 20; i++) begin
      if ((edges % 16) == 15) break;
      tick();
    end
    check("cnt4_max", io_rdata4, 32'd15);
    tick();
    check("cnt4_wrap", io_rdata4, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
